// File: rtl/lsu_dmem.sv
// lsu_dmem -- MEM-stage load/store unit with a byte-addressable data memory.
//
// Stores are aligned into byte lanes and written with a byte mask. Loads are
// read, shifted down and sign/zero-extended. Accesses that cross a word
// boundary are either split into two word beats (word A, then word B) or
// rejected with err, depending on the build option below.
//
// Build option:
//   LSU_MISALIGN_SPLIT_EN  defined   -> misaligned accesses take two beats
//                                       through the SPLIT state (busy=1 for
//                                       one cycle).
//                          undefined -> misaligned accesses raise err; no
//                                       SPLIT state, busy tied to 0.
//
// Parameters:
//   DEPTH_LOG2  log2 of the memory depth in 32-bit words (default 1024 words).
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset (memory contents are kept)
//   req        access request
//   addr       byte address; word index = addr[DEPTH_LOG2+1:2]
//   we         store byte strobe: 0001 SB, 0011 SH, 1111 SW, 0000 load
//   funct3     load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   wdata      right-aligned store data
//   busy       second beat of a split access is pending
//   rvalid     one-cycle pulse, rdata carries a new load result
//   rdata      extended load result, held until the next load result
//   err        one-cycle pulse for an illegal access
//   state_dbg  FSM state for observation: 0 = IDLE, 1 = SPLIT
//
// Handshake: a request is accepted on a rising edge where req=1, busy=0 and
// rst_n=1. While busy=1 req is ignored and the requester holds its inputs.
module lsu_dmem #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic [3:0]  we,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        state_dbg
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] f3);
        case (f3)
            3'b000:  extend = {{24{v[7]}}, v[7:0]};
            3'b001:  extend = {{16{v[15]}}, v[15:0]};
            3'b100:  extend = {24'h000000, v[7:0]};
            3'b101:  extend = {16'h0000, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    logic [31:0]           mem [DEPTH];

    logic [1:0]            off;
    logic [DEPTH_LOG2-1:0] idx_a;
    logic                  is_load;
    logic [3:0]            size_mask;
    logic                  bad_type;
    logic [6:0]            mask7;
    logic [55:0]           wdata56;
    logic                  misaligned;
    logic                  accept;
    logic                  bad;

    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [3:0]            wr_mask;
    logic [31:0]           wr_data;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [31:0]           rd_word;
    logic [31:0]           aligned_word;
    logic                  unused_bits;

    assign off     = addr[1:0];
    assign idx_a   = addr[DEPTH_LOG2+1:2];
    assign is_load = (we == 4'b0000);

    // Access size as a right-aligned lane mask; anything not in the legal
    // store-strobe / load-type set is flagged.
    always_comb begin
        size_mask = 4'b0000;
        bad_type  = 1'b0;
        if (is_load) begin
            case (funct3)
                3'b000, 3'b100: size_mask = 4'b0001;
                3'b001, 3'b101: size_mask = 4'b0011;
                3'b010:         size_mask = 4'b1111;
                default:        bad_type  = 1'b1;
            endcase
        end else begin
            case (we)
                4'b0001, 4'b0011, 4'b1111: size_mask = we;
                default:                   bad_type  = 1'b1;
            endcase
        end
    end

    // Lanes [3:0] belong to word A, lanes [6:4] spill into word B.
    assign mask7      = {3'b000, size_mask} << off;
    assign wdata56    = {24'h000000, wdata} << {off, 3'b000};
    assign misaligned = |mask7[6:4];
    assign accept     = rst_n & req & ~busy;

    assign rd_word      = mem[rd_idx];
    assign aligned_word = rd_word >> {off, 3'b000};

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  split_go;
    logic [DEPTH_LOG2-1:0] idx_b;

    // Word-B half of the access, captured at accept so the second beat does
    // not depend on the requester's held inputs.
    logic [DEPTH_LOG2-1:0] b_idx;
    logic [2:0]            b_mask;
    logic [23:0]           b_data;
    logic                  b_load;
    logic [2:0]            b_funct3;
    logic [1:0]            b_off;
    logic [31:0]           a_hold;
    logic [31:0]           merged;

    // Index arithmetic wraps naturally from DEPTH-1 to 0.
    assign idx_b    = idx_a + DEPTH_LOG2'(1);
    assign bad      = bad_type;
    assign split_go = accept & ~bad_type & misaligned;
    assign busy     = (state == SPLIT);
    assign state_dbg = (state == SPLIT);

    // Low bytes come from the held word A, high bytes from word B.
    assign merged = 32'({rd_word[23:0], a_hold} >> {b_off, 3'b000});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (split_go) state_next = SPLIT;
            SPLIT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (split_go) begin
            b_idx    <= idx_b;
            b_mask   <= mask7[6:4];
            b_data   <= wdata56[55:32];
            b_load   <= is_load;
            b_funct3 <= funct3;
            b_off    <= off;
            a_hold   <= rd_word;
        end
    end

    assign unused_bits = ^addr[31:DEPTH_LOG2+2];
`else
    assign bad         = bad_type | misaligned;
    assign busy        = 1'b0;
    assign state_dbg   = 1'b0;
    assign unused_bits = ^{addr[31:DEPTH_LOG2+2], wdata56[55:32]};
`endif

    // Single read port and single write port: beat A and beat B never share
    // a cycle because a new accept needs busy=0.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = idx_a;
        wr_mask = mask7[3:0];
        wr_data = wdata56[31:0];
        rd_idx  = idx_a;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (busy) begin
            rd_idx  = b_idx;
            wr_idx  = b_idx;
            wr_mask = {1'b0, b_mask};
            wr_data = {8'h00, b_data};
            // rst_n gating drops the word-B beat when reset lands in SPLIT.
            wr_en   = rst_n & ~b_load;
        end else
`endif
        wr_en = accept & ~is_load & ~bad;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= 32'h0000_0000;
            err    <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            err    <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            if (busy && b_load) begin
                rvalid <= 1'b1;
                rdata  <= extend(merged, b_funct3);
            end
            if (accept) begin
                if (bad) begin
                    err <= 1'b1;
                end else if (is_load && !misaligned) begin
                    rvalid <= 1'b1;
                    rdata  <= extend(aligned_word, funct3);
                end
            end
`else
            if (accept) begin
                if (bad) begin
                    err <= 1'b1;
                end else if (is_load) begin
                    rvalid <= 1'b1;
                    rdata  <= extend(aligned_word, funct3);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_lsu_dmem.sv
// Bench for lsu_dmem: directed scenarios plus randomized accesses checked
// against a byte-array reference memory.
module tb_lsu_dmem;

  localparam int NB = 4096;  // bytes in the default 1024-word memory

  typedef struct {
    int          lat;
    int          rv_cnt;
    logic [31:0] rd;
    int          err_cnt;
    int          err_cyc;
    int          busy_cnt;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic [3:0]  we;
  logic [2:0]  funct3;
  logic [31:0] wdata;
  logic        busy;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        state_dbg;

  int errors = 0;
  int checks = 0;

  logic [7:0]  ref_mem [NB];
  logic [31:0] exp_q[$];

  lsu_dmem dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .we(we),
    .funct3(funct3), .wdata(wdata), .busy(busy), .rvalid(rvalid),
    .rdata(rdata), .err(err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: byte-addressed memory, wraps modulo the memory size.
  function automatic void model(input logic [31:0] a, input logic [3:0] w,
                                input logic [2:0] f, input logic [31:0] d,
                                output bit e_err, output int e_lat, output int e_busy);
    int size;
    bit load;
    bit legal;
    bit mis;
    int base;
    logic [31:0] val;
    size = 0;
    load = (w == 4'b0000);
    legal = 1'b1;
    if (load) begin
      case (f)
        3'd0, 3'd4: size = 1;
        3'd1, 3'd5: size = 2;
        3'd2:       size = 4;
        default:    legal = 1'b0;
      endcase
    end else begin
      case (w)
        4'd1:    size = 1;
        4'd3:    size = 2;
        4'd15:   size = 4;
        default: legal = 1'b0;
      endcase
    end
    base = int'(a[11:0]);
    mis = legal && (int'(a[1:0]) + size > 4);
`ifndef LSU_MISALIGN_SPLIT_EN
    if (mis) legal = 1'b0;
`endif
    e_err = !legal;
    e_lat = 0;
    e_busy = 0;
    if (!legal) return;
    if (mis) e_busy = 1;
    if (load) begin
      val = 32'h0;
      for (int k = 0; k < size; k++) val |= 32'(ref_mem[(base + k) % NB]) << (8 * k);
      if (!f[2] && size < 4 && val[8*size-1]) val |= 32'hFFFF_FFFF << (8 * size);
      exp_q.push_back(val);
      e_lat = mis ? 2 : 1;
    end else begin
      for (int k = 0; k < size; k++) ref_mem[(base + k) % NB] = d[8*k +: 8];
    end
  endfunction

  // driver: one request, then observe four cycles after the accepting edge
  task automatic issue(input logic [31:0] a, input logic [3:0] w, input logic [2:0] f,
                       input logic [31:0] d, output obs_t o,
                       output bit e_err, output int e_lat, output int e_busy);
    int guard;
    guard = 0;
    o.lat = 0; o.rv_cnt = 0; o.rd = 32'h0; o.err_cnt = 0; o.err_cyc = 0; o.busy_cnt = 0;
    @(negedge clk);
    while (busy !== 1'b0 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8) begin
      checks++; errors++;
      $display("FAIL idle_wait: busy=%b, required 0", busy);
    end
    model(a, w, f, d, e_err, e_lat, e_busy);
    req = 1'b1; addr = a; we = w; funct3 = f; wdata = d;
    @(negedge clk);
    req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (busy === 1'b1) o.busy_cnt++;
      if (err === 1'b1) begin
        o.err_cnt++;
        if (o.err_cyc == 0) o.err_cyc = c;
      end
      if (rvalid === 1'b1) begin
        o.rv_cnt++;
        if (o.lat == 0) begin
          o.lat = c;
          o.rd = rdata;
        end
      end
      if (c < 4) @(negedge clk);
    end
  endtask

  task automatic init_mem();
    bit e_err;
    int e_lat, e_busy;
    logic [31:0] d;
    for (int i = 0; i < NB / 4; i++) begin
      @(negedge clk);
      d = $urandom;
      model(32'(i * 4), 4'hF, 3'b010, d, e_err, e_lat, e_busy);
      req = 1'b1; addr = 32'(i * 4); we = 4'hF; funct3 = 3'b010; wdata = d;
    end
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 1'b0; addr = 32'h0; we = 4'h0; funct3 = 3'b000; wdata = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 || state_dbg !== 1'b0)
      begin errors++; $display("FAIL reset_outputs: busy=%b rvalid=%b err=%b rdata=%h state=%b, required 0", busy, rvalid, err, rdata, state_dbg); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word();
    obs_t o; bit e_err; int e_lat, e_busy; logic [31:0] exp;
    issue(32'h10, 4'hF, 3'b010, 32'hDEADBEEF, o, e_err, e_lat, e_busy);
    checks++;
    if (o.err_cnt !== 0 || o.rv_cnt !== 0) begin errors++; $display("FAIL sw_quiet: err=%0d rvalid=%0d, required 0 0", o.err_cnt, o.rv_cnt); end
    issue(32'h10, 4'h0, 3'b010, 32'h0, o, e_err, e_lat, e_busy);
    exp = exp_q.pop_front();
    checks++;
    if (o.lat !== 1 || o.rv_cnt !== 1) begin errors++; $display("FAIL lw_latency: lat=%0d pulses=%0d, required 1 1", o.lat, o.rv_cnt); end
    checks++;
    if (o.rd !== 32'hDEADBEEF || o.rd !== exp) begin errors++; $display("FAIL lw_data: %h, required %h", o.rd, 32'hDEADBEEF); end
    issue(32'h30, 4'hF, 3'b010, 32'h01020304, o, e_err, e_lat, e_busy);
    checks++;
    if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold: %h, required deadbeef", rdata); end
  endtask

  task automatic test_byte();
    obs_t o; bit e_err; int e_lat, e_busy; logic [31:0] exp;
    issue(32'h13, 4'h1, 3'b000, 32'hFFFF_FF80, o, e_err, e_lat, e_busy);
    issue(32'h13, 4'h0, 3'b000, 32'h0, o, e_err, e_lat, e_busy);
    exp = exp_q.pop_front();
    checks++;
    if (o.rd !== 32'hFFFFFF80 || o.rd !== exp) begin errors++; $display("FAIL lb_sign: %h, required ffffff80", o.rd); end
    issue(32'h13, 4'h0, 3'b100, 32'h0, o, e_err, e_lat, e_busy);
    exp = exp_q.pop_front();
    checks++;
    if (o.rd !== 32'h00000080 || o.rd !== exp) begin errors++; $display("FAIL lbu_zero: %h, required 00000080", o.rd); end
    issue(32'h10, 4'h0, 3'b010, 32'h0, o, e_err, e_lat, e_busy);
    exp = exp_q.pop_front();
    checks++;
    if (o.rd !== 32'h80ADBEEF || o.rd !== exp) begin errors++; $display("FAIL sb_neighbours: %h, required 80adbeef", o.rd); end
  endtask

  task automatic test_half_illegal();
    obs_t o; bit e_err; int e_lat, e_busy; logic [31:0] exp;
    issue(32'h12, 4'h3, 3'b000, 32'hABCD_1234, o, e_err, e_lat, e_busy);
    issue(32'h12, 4'h0, 3'b101, 32'h0, o, e_err, e_lat, e_busy);
    exp = exp_q.pop_front();
    checks++;
    if (o.rd !== 32'h00001234 || o.rd !== exp) begin errors++; $display("FAIL lhu: %h, required 00001234", o.rd); end
    issue(32'h10, 4'h5, 3'b000, 32'hFFFF_FFFF, o, e_err, e_lat, e_busy);
    checks++;
    if (o.err_cnt !== 1 || o.err_cyc !== 1 || o.rv_cnt !== 0) begin errors++; $display("FAIL illegal_we: err=%0d at cycle %0d rvalid=%0d, required 1 1 0", o.err_cnt, o.err_cyc, o.rv_cnt); end
    issue(32'h10, 4'h0, 3'b011, 32'h0, o, e_err, e_lat, e_busy);
    checks++;
    if (o.err_cnt !== 1 || o.rv_cnt !== 0) begin errors++; $display("FAIL illegal_f3: err=%0d rvalid=%0d, required 1 0", o.err_cnt, o.rv_cnt); end
    issue(32'h10, 4'h0, 3'b010, 32'h0, o, e_err, e_lat, e_busy);
    exp = exp_q.pop_front();
    checks++;
    if (o.rd !== 32'h1234BEEF || o.rd !== exp) begin errors++; $display("FAIL illegal_nowrite: %h, required 1234beef", o.rd); end
  endtask

  task automatic test_misaligned();
    obs_t o; bit e_err; int e_lat, e_busy; logic [31:0] exp;
`ifdef LSU_MISALIGN_SPLIT_EN
    issue(32'h21, 4'hF, 3'b010, 32'hAABBCCDD, o, e_err, e_lat, e_busy);
    checks++;
    if (o.busy_cnt !== 1 || o.err_cnt !== 0 || o.rv_cnt !== 0) begin errors++; $display("FAIL split_sw: busy=%0d err=%0d rvalid=%0d, required 1 0 0", o.busy_cnt, o.err_cnt, o.rv_cnt); end
    issue(32'h20, 4'h0, 3'b010, 32'h0, o, e_err, e_lat, e_busy);
    exp = exp_q.pop_front();
    checks++;
    if (o.rd[31:8] !== 24'hBBCCDD || o.rd !== exp) begin errors++; $display("FAIL split_word_a: %h, required bbccdd in [31:8]", o.rd); end
    issue(32'h24, 4'h0, 3'b100, 32'h0, o, e_err, e_lat, e_busy);
    exp = exp_q.pop_front();
    checks++;
    if (o.rd !== 32'h000000AA || o.rd !== exp) begin errors++; $display("FAIL split_word_b: %h, required 000000aa", o.rd); end
    issue(32'h21, 4'h0, 3'b010, 32'h0, o, e_err, e_lat, e_busy);
    exp = exp_q.pop_front();
    checks++;
    if (o.lat !== 2 || o.rv_cnt !== 1 || o.busy_cnt !== 1) begin errors++; $display("FAIL split_lw_timing: lat=%0d pulses=%0d busy=%0d, required 2 1 1", o.lat, o.rv_cnt, o.busy_cnt); end
    checks++;
    if (o.rd !== 32'hAABBCCDD || o.rd !== exp) begin errors++; $display("FAIL split_lw_data: %h, required aabbccdd", o.rd); end
`else
    issue(32'h03, 4'h0, 3'b001, 32'h0, o, e_err, e_lat, e_busy);
    checks++;
    if (o.err_cnt !== 1 || o.err_cyc !== 1 || o.rv_cnt !== 0 || o.busy_cnt !== 0) begin errors++; $display("FAIL mis_lh: err=%0d at %0d rvalid=%0d busy=%0d, required 1 1 0 0", o.err_cnt, o.err_cyc, o.rv_cnt, o.busy_cnt); end
    issue(32'h21, 4'hF, 3'b010, 32'hAABBCCDD, o, e_err, e_lat, e_busy);
    checks++;
    if (o.err_cnt !== 1 || o.busy_cnt !== 0) begin errors++; $display("FAIL mis_sw: err=%0d busy=%0d, required 1 0", o.err_cnt, o.busy_cnt); end
    issue(32'h20, 4'h0, 3'b010, 32'h0, o, e_err, e_lat, e_busy);
    exp = exp_q.pop_front();
    checks++;
    if (o.rd !== exp) begin errors++; $display("FAIL mis_nowrite: %h, required %h", o.rd, exp); end
`endif
  endtask

  task automatic test_wrap();
    obs_t o; bit e_err; int e_lat, e_busy; logic [31:0] exp;
    issue(32'h0000_0FFE, 4'hF, 3'b010, 32'h11223344, o, e_err, e_lat, e_busy);
    checks++;
    if (o.err_cnt !== (e_err ? 1 : 0) || o.busy_cnt !== e_busy) begin errors++; $display("FAIL wrap_sw: err=%0d busy=%0d, required %0d %0d", o.err_cnt, o.busy_cnt, e_err, e_busy); end
    issue(32'h0, 4'h0, 3'b010, 32'h0, o, e_err, e_lat, e_busy);
    exp = exp_q.pop_front();
    checks++;
    if (o.rd !== exp) begin errors++; $display("FAIL wrap_word0: %h, required %h", o.rd, exp); end
`ifdef LSU_MISALIGN_SPLIT_EN
    checks++;
    if (o.rd[15:0] !== 16'h1122) begin errors++; $display("FAIL wrap_upper_half: %h, required 1122", o.rd[15:0]); end
`endif
  endtask

  task automatic test_back_to_back();
    bit e_err; int e_lat, e_busy; logic [31:0] exp;
    @(negedge clk);
    model(32'h10, 4'h0, 3'b010, 32'h0, e_err, e_lat, e_busy);
    req = 1'b1; addr = 32'h10; we = 4'h0; funct3 = 3'b010;
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (rvalid !== 1'b1 || rdata !== exp) begin errors++; $display("FAIL b2b_first: rvalid=%b rdata=%h, required 1 %h", rvalid, rdata, exp); end
    model(32'h13, 4'h0, 3'b100, 32'h0, e_err, e_lat, e_busy);
    addr = 32'h13; funct3 = 3'b100;
    @(negedge clk);
    req = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (rvalid !== 1'b1 || rdata !== exp) begin errors++; $display("FAIL b2b_second: rvalid=%b rdata=%h, required 1 %h", rvalid, rdata, exp); end
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL b2b_pulse: rvalid=%b, required 0", rvalid); end
  endtask

`ifdef LSU_MISALIGN_SPLIT_EN
  task automatic test_reset_split();
    obs_t o; bit e_err; int e_lat, e_busy; logic [31:0] exp;
    @(negedge clk);
    req = 1'b1; addr = 32'h0000_0FFE; we = 4'hF; funct3 = 3'b010; wdata = 32'h55667788;
    @(negedge clk);
    req = 1'b0;
    checks++;
    if (busy !== 1'b1 || state_dbg !== 1'b1) begin errors++; $display("FAIL rst_split_enter: busy=%b state=%b, required 1 1", busy, state_dbg); end
    // only the word-A bytes are committed
    ref_mem[12'hFFE] = 8'h88;
    ref_mem[12'hFFF] = 8'h77;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL rst_split_abort: busy=%b rvalid=%b rdata=%h, required 0 0 0", busy, rvalid, rdata); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_split_after: rvalid=%b busy=%b, required 0 0", rvalid, busy); end
    issue(32'h0, 4'h0, 3'b010, 32'h0, o, e_err, e_lat, e_busy);
    exp = exp_q.pop_front();
    checks++;
    if (o.rd !== exp) begin errors++; $display("FAIL rst_split_word_b: %h, required %h", o.rd, exp); end
    issue(32'h0FFC, 4'h0, 3'b010, 32'h0, o, e_err, e_lat, e_busy);
    exp = exp_q.pop_front();
    checks++;
    if (o.rd[31:16] !== 16'h7788 || o.rd !== exp) begin errors++; $display("FAIL rst_split_word_a: %h, required %h", o.rd, exp); end
  endtask
`endif

  task automatic test_random();
    obs_t o; bit e_err; int e_lat, e_busy; logic [31:0] exp;
    logic [31:0] a; logic [3:0] w; logic [2:0] f; int r;
    for (int n = 0; n < 300; n++) begin
      a = $urandom & 32'hFFFF_F000;
      if ($urandom_range(0, 3) == 0) a |= 32'($urandom_range(12'hFC0, 12'hFFF));
      else a |= 32'($urandom_range(0, 12'h3F));
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: w = 4'h0;
        4, 9:       w = 4'h1;
        5:          w = 4'h3;
        6, 7:       w = 4'hF;
        default:    w = 4'($urandom_range(0, 15));
      endcase
      f = 3'($urandom_range(0, 7));
      issue(a, w, f, $urandom, o, e_err, e_lat, e_busy);
      checks++;
      if (o.err_cnt !== (e_err ? 1 : 0)) begin errors++; $display("FAIL rnd_err a=%h we=%b f3=%b: err=%0d, required %0d", a, w, f, o.err_cnt, e_err); end
      checks++;
      if (o.busy_cnt !== e_busy) begin errors++; $display("FAIL rnd_busy a=%h we=%b f3=%b: busy=%0d, required %0d", a, w, f, o.busy_cnt, e_busy); end
      checks++;
      if (o.lat !== e_lat || o.rv_cnt !== (e_lat != 0 ? 1 : 0)) begin errors++; $display("FAIL rnd_rvalid a=%h we=%b f3=%b: lat=%0d pulses=%0d, required %0d", a, w, f, o.lat, o.rv_cnt, e_lat); end
      if (e_lat != 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (o.rd !== exp) begin errors++; $display("FAIL rnd_rdata a=%h f3=%b: %h, required %h", a, f, o.rd, exp); end
      end
    end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_word();
    test_byte();
    test_half_illegal();
    test_misaligned();
    test_wrap();
    test_back_to_back();
`ifdef LSU_MISALIGN_SPLIT_EN
    test_reset_split();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
